// File: rtl/y86_pkg.sv
// Shared Y86 pipeline definitions: loader state encoding, fetch window size, stat codes.
package y86_pkg;

  localparam int unsigned INSTR_WIN_BYTES = 10;
  localparam int unsigned INSTR_WIN_W     = 8 * INSTR_WIN_BYTES;

  typedef enum logic [1:0] {
    IMEM_CLEAR = 2'd0,
    IMEM_LOAD  = 2'd1,
    IMEM_RUN   = 2'd2,
    IMEM_ERR   = 2'd3
  } imem_state_e;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

endpackage

// File: rtl/imem_window.sv
// Combinational 10-byte little-endian fetch window; bytes past the end of memory read 0x00.
module imem_window
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic [7:0]             mem [MEM_BYTES],
  input  logic [63:0]            pc,
  input  logic                   en,
  output logic [INSTR_WIN_W-1:0] win_c
);

  // Extract each byte; the sum is 65-bit so pc near 2^64 never wraps into low memory.
  always_comb begin
    logic [64:0] addr;
    addr  = '0;
    win_c = '0;
    for (int k = 0; k < int'(INSTR_WIN_BYTES); k++) begin
      addr = {1'b0, pc} + 65'(k);
      if (en && (addr < 65'(MEM_BYTES))) begin
        win_c[8*k +: 8] = mem[addr[ADDR_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with zero-fill after reset, byte-stream program loader and fetch window.
module imem_loader
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [7:0]             ld_data,
  input  logic                   ld_last,
  input  logic                   ld_restart,
  output logic [ADDR_W:0]        ld_count,
  output logic                   ld_err,
  output logic                   cpu_run,
  input  logic [63:0]            f_pc,
  output logic [INSTR_WIN_W-1:0] f_bytes,
  output logic                   f_imem_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  ld_count_q, ld_count_d;
  logic              ld_err_q, ld_err_d;
  logic              ld_ready_q, ld_ready_d;
  logic              cpu_run_q, cpu_run_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_q [MEM_BYTES];

  logic              beat;

  assign beat = ld_valid && ld_ready_q;

  // Next-state, pointer updates and the single memory write port.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    ld_count_d = ld_count_q;
    ld_err_d   = ld_err_q;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    unique case (state_q)
      IMEM_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == ADDR_W'(MEM_BYTES - 1)) begin
          state_d = IMEM_LOAD;
        end
      end
      IMEM_LOAD: begin
        if (beat) begin
          if (wr_ptr_q == CNT_W'(MEM_BYTES)) begin
            ld_err_d = 1'b1;
            state_d  = IMEM_ERR;
          end else begin
            mem_we    = 1'b1;
            mem_addr  = wr_ptr_q[ADDR_W-1:0];
            mem_wdata = ld_data;
            wr_ptr_d  = wr_ptr_q + CNT_W'(1);
            if (ld_count_q != CNT_W'(MEM_BYTES)) begin
              ld_count_d = ld_count_q + CNT_W'(1);
            end
            if (ld_last) begin
              state_d = IMEM_RUN;
            end
          end
        end
      end
      IMEM_RUN, IMEM_ERR: begin
        if (ld_restart) begin
          state_d    = IMEM_CLEAR;
          clr_ptr_d  = '0;
          wr_ptr_d   = '0;
          ld_count_d = '0;
          ld_err_d   = 1'b0;
        end
      end
      default: state_d = IMEM_CLEAR;
    endcase

    ld_ready_d = (state_d == IMEM_LOAD);
    cpu_run_d  = (state_d == IMEM_RUN);
  end

  // Control state and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IMEM_CLEAR;
      clr_ptr_q  <= '0;
      wr_ptr_q   <= '0;
      ld_count_q <= '0;
      ld_err_q   <= 1'b0;
      ld_ready_q <= 1'b0;
      cpu_run_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ld_count_q <= ld_count_d;
      ld_err_q   <= ld_err_d;
      ld_ready_q <= ld_ready_d;
      cpu_run_q  <= cpu_run_d;
    end
  end

  // Memory array: contents are initialised by the CLEAR sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  imem_window #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_window (
    .mem   (mem_q),
    .pc    (f_pc),
    .en    (cpu_run_q),
    .win_c (f_bytes)
  );

  assign ld_ready   = ld_ready_q;
  assign ld_count   = ld_count_q;
  assign ld_err     = ld_err_q;
  assign cpu_run    = cpu_run_q;
  assign f_imem_err = (f_pc >= 64'(MEM_BYTES)) && cpu_run_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clear timing, loading, fetch window edges, overflow, reset.
module tb_imem_loader;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned ADDR_W    = 10;

  logic          clk;
  logic          rst_n;
  logic          ld_valid;
  logic          ld_ready;
  logic [7:0]    ld_data;
  logic          ld_last;
  logic          ld_restart;
  logic [ADDR_W:0] ld_count;
  logic          ld_err;
  logic          cpu_run;
  logic [63:0]   f_pc;
  logic [79:0]   f_bytes;
  logic          f_imem_err;

  int errors;
  int checks;

  imem_loader #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_restart (ld_restart),
    .ld_count   (ld_count),
    .ld_err     (ld_err),
    .cpu_run    (cpu_run),
    .f_pc       (f_pc),
    .f_bytes    (f_bytes),
    .f_imem_err (f_imem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count rising edges until ld_ready rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ld_ready && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = l;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 8'hEE;
  endtask

  task automatic idle_cycle();
    ld_valid = 1'b0;
    ld_data  = 8'hEE;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    ld_restart = 1'b1;
    @(posedge clk);
    #1;
    ld_restart = 1'b0;
  endtask

  initial begin
    int n;
    int i;
    int g;
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = 8'h00;
    ld_last    = 1'b0;
    ld_restart = 1'b0;
    f_pc       = 64'd0;

    // Reset and initial clear sweep
    repeat (3) @(posedge clk);
    #1;
    check("rst_ld_ready", 80'(ld_ready), 80'd0);
    check("rst_cpu_run", 80'(cpu_run), 80'd0);
    check("rst_ld_count", 80'(ld_count), 80'd0);
    check("rst_ld_err", 80'(ld_err), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    f_pc  = 64'd5;
    #1;
    check("clear_f_bytes", f_bytes, 80'd0);
    check("clear_f_imem_err_lowpc", 80'(f_imem_err), 80'd0);
    f_pc = 64'd4096;
    #1;
    check("clear_f_imem_err_highpc", 80'(f_imem_err), 80'd0);
    wait_ready(n);
    check("clear_len_1", 80'(n), 80'(MEM_BYTES));
    check("clear_cpu_run", 80'(cpu_run), 80'd0);

    // irmovq $10,%rsp program
    send_byte(8'h30, 1'b0);
    send_byte(8'hF4, 1'b0);
    send_byte(8'h0A, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(8'h00, 1'b0);
    check("prog_not_run_yet", 80'(cpu_run), 80'd0);
    send_byte(8'h00, 1'b1);
    check("prog_cpu_run", 80'(cpu_run), 80'd1);
    check("prog_ld_count", 80'(ld_count), 80'd10);
    check("prog_ld_ready", 80'(ld_ready), 80'd0);
    f_pc = 64'd0;
    #1;
    check("prog_win_pc0", f_bytes, 80'h000000000000000AF430);
    check("prog_imem_err_pc0", 80'(f_imem_err), 80'd0);
    f_pc = 64'd1;
    #1;
    check("prog_win_pc1", f_bytes, 80'h00000000000000000AF4);
    f_pc = 64'd10;
    #1;
    check("prog_win_unloaded", f_bytes, 80'd0);

    // Gapped load of six bytes
    pulse_restart();
    check("restart_cpu_run", 80'(cpu_run), 80'd0);
    check("restart_ld_count", 80'(ld_count), 80'd0);
    wait_ready(n);
    check("clear_len_2", 80'(n), 80'(MEM_BYTES));
    i = 0;
    g = 0;
    while (i < 6 && g < 200) begin
      if ($urandom_range(0, 1) == 1) begin
        send_byte(8'hA0 + 8'(i), i == 5);
        i++;
      end else begin
        idle_cycle();
      end
      g++;
    end
    check("gap_bytes_sent", 80'(i), 80'd6);
    check("gap_ld_count", 80'(ld_count), 80'd6);
    check("gap_cpu_run", 80'(cpu_run), 80'd1);
    f_pc = 64'd0;
    #1;
    check("gap_win_pc0", f_bytes, 80'h00000000A5A4A3A2A1A0);

    // Full memory of 0x11 and end-of-memory window
    pulse_restart();
    wait_ready(n);
    check("clear_len_3", 80'(n), 80'(MEM_BYTES));
    for (int k = 0; k < int'(MEM_BYTES); k++) send_byte(8'h11, k == int'(MEM_BYTES) - 1);
    check("full_cpu_run", 80'(cpu_run), 80'd1);
    check("full_ld_count", 80'(ld_count), 80'(MEM_BYTES));
    check("full_ld_err", 80'(ld_err), 80'd0);
    f_pc = 64'(MEM_BYTES - 3);
    #1;
    check("end_win_bytes", f_bytes, 80'h00000000000000111111);
    check("end_win_err", 80'(f_imem_err), 80'd0);
    f_pc = 64'(MEM_BYTES - 10);
    #1;
    check("end_win_full", f_bytes, 80'h11111111111111111111);
    f_pc = 64'(MEM_BYTES);
    #1;
    check("oob_err", 80'(f_imem_err), 80'd1);
    check("oob_bytes", f_bytes, 80'd0);
    f_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    check("nowrap_bytes", f_bytes, 80'd0);
    check("nowrap_err", 80'(f_imem_err), 80'd1);

    // Overflow into ERR
    pulse_restart();
    wait_ready(n);
    check("clear_len_4", 80'(n), 80'(MEM_BYTES));
    for (int k = 0; k < int'(MEM_BYTES); k++) send_byte(8'h5A, 1'b0);
    check("fill_ld_count", 80'(ld_count), 80'(MEM_BYTES));
    check("fill_ld_ready", 80'(ld_ready), 80'd1);
    check("fill_ld_err", 80'(ld_err), 80'd0);
    send_byte(8'h99, 1'b1);
    check("ovf_ld_err", 80'(ld_err), 80'd1);
    check("ovf_ld_ready", 80'(ld_ready), 80'd0);
    check("ovf_cpu_run", 80'(cpu_run), 80'd0);
    check("ovf_ld_count_sat", 80'(ld_count), 80'(MEM_BYTES));
    f_pc = 64'd0;
    repeat (3) idle_cycle();
    check("err_hold_ld_err", 80'(ld_err), 80'd1);
    check("err_f_bytes", f_bytes, 80'd0);
    pulse_restart();
    check("err_restart_ld_err", 80'(ld_err), 80'd0);
    check("err_restart_count", 80'(ld_count), 80'd0);
    wait_ready(n);
    check("clear_len_5", 80'(n), 80'(MEM_BYTES));

    // Reset in the middle of a load
    for (int k = 0; k < 5; k++) send_byte(8'h77, 1'b0);
    check("midload_count", 80'(ld_count), 80'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ld_ready", 80'(ld_ready), 80'd0);
    check("async_rst_ld_count", 80'(ld_count), 80'd0);
    check("async_rst_cpu_run", 80'(cpu_run), 80'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    check("clear_len_6", 80'(n), 80'(MEM_BYTES));
    send_byte(8'hB1, 1'b0);
    send_byte(8'hB2, 1'b1);
    check("reload_count", 80'(ld_count), 80'd2);
    f_pc = 64'd0;
    #1;
    check("reload_win_pc0", f_bytes, 80'h0000000000000000B2B1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
